// File: rtl/priority_rr_arbiter.sv
// N-port request/grant arbiter: fixed-priority or round-robin selection with
// optional grant blocking (hold while requested, or hold until acknowledged).
module priority_rr_arbiter #(
  parameter int unsigned PORTS                 = 4,
  parameter int unsigned ARB_TYPE_ROUND_ROBIN  = 0,
  parameter int unsigned ARB_BLOCK             = 0,
  parameter int unsigned ARB_BLOCK_ACK         = 1,
  parameter int unsigned ARB_LSB_HIGH_PRIORITY = 0,
  localparam int unsigned IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] request,
  input  logic [PORTS-1:0] acknowledge,
  output logic [PORTS-1:0] grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_encoded
);

  logic [PORTS-1:0] mask;
  logic [PORTS-1:0] mask_next;
  logic [PORTS-1:0] grant_next;
  logic             valid_next;
  logic [IDX_W-1:0] enc_next;
  logic [PORTS-1:0] req_masked;
  logic [IDX_W-1:0] win_idx;
  logic             hold_req;
  logic             hold_ack;

  // Priority encoder; the later loop iteration wins, so scan order sets priority.
  function automatic logic [IDX_W-1:0] pri_enc(input logic [PORTS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(PORTS); i++) begin
      if (ARB_LSB_HIGH_PRIORITY != 0) begin
        if (v[int'(PORTS) - 1 - i]) idx = IDX_W'(int'(PORTS) - 1 - i);
      end else begin
        if (v[i]) idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic [PORTS-1:0] one_hot(input logic [IDX_W-1:0] idx);
    logic [PORTS-1:0] v;
    v = '0;
    for (int j = 0; j < int'(PORTS); j++) v[j] = (int'(idx) == j);
    return v;
  endfunction

  // Round-robin mask leaves only the ports that follow idx in priority order.
  function automatic logic [PORTS-1:0] rr_mask(input logic [IDX_W-1:0] idx);
    logic [PORTS-1:0] v;
    v = '0;
    for (int j = 0; j < int'(PORTS); j++) begin
      v[j] = (ARB_LSB_HIGH_PRIORITY != 0) ? (j > int'(idx)) : (j < int'(idx));
    end
    return v;
  endfunction

  assign req_masked = request & mask;
  assign hold_req   = (ARB_BLOCK != 0) && (ARB_BLOCK_ACK == 0) && (|(grant & request));
  assign hold_ack   = (ARB_BLOCK != 0) && (ARB_BLOCK_ACK != 0) && grant_valid &&
                      !(|(grant & acknowledge));

  // Next-state selection: hold, arbitrate, or idle.
  always_comb begin
    grant_next = grant;
    valid_next = grant_valid;
    enc_next   = grant_encoded;
    mask_next  = mask;
    if ((ARB_TYPE_ROUND_ROBIN != 0) && (|req_masked)) begin
      win_idx = pri_enc(req_masked);
    end else begin
      win_idx = pri_enc(request);
    end
    if (hold_req || hold_ack) begin
      grant_next = grant;
    end else if (|request) begin
      grant_next = one_hot(win_idx);
      valid_next = 1'b1;
      enc_next   = win_idx;
      if (ARB_TYPE_ROUND_ROBIN != 0) mask_next = rr_mask(win_idx);
    end else begin
      grant_next = '0;
      valid_next = 1'b0;
      enc_next   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant         <= '0;
      grant_valid   <= 1'b0;
      grant_encoded <= '0;
      mask          <= '0;
    end else begin
      grant         <= grant_next;
      grant_valid   <= valid_next;
      grant_encoded <= enc_next;
      mask          <= mask_next;
    end
  end

endmodule

// File: tb/tb_priority_rr_arbiter.sv
// Five arbiter configurations driven by shared stimulus and checked against a
// circular-search reference model.
module tb_priority_rr_arbiter;

  localparam int NC = 5;
  localparam int RR_C [NC] = '{1, 0, 0, 1, 1};
  localparam int BLK_C[NC] = '{1, 0, 1, 0, 1};
  localparam int ACK_C[NC] = '{1, 1, 0, 1, 0};
  localparam int LSB_C[NC] = '{1, 0, 1, 1, 0};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] request = '0;
  logic [3:0] acknowledge = '0;
  logic [NC-1:0][3:0] gr;
  logic [NC-1:0]      gv;
  logic [NC-1:0][1:0] ge;

  int m_idx [NC];
  int m_last[NC];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  priority_rr_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1), .ARB_LSB_HIGH_PRIORITY(1))
    u0 (.clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge), .grant(gr[0]), .grant_valid(gv[0]), .grant_encoded(ge[0]));
  priority_rr_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(0), .ARB_BLOCK_ACK(1), .ARB_LSB_HIGH_PRIORITY(0))
    u1 (.clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge), .grant(gr[1]), .grant_valid(gv[1]), .grant_encoded(ge[1]));
  priority_rr_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(1), .ARB_BLOCK_ACK(0), .ARB_LSB_HIGH_PRIORITY(1))
    u2 (.clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge), .grant(gr[2]), .grant_valid(gv[2]), .grant_encoded(ge[2]));
  priority_rr_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(0), .ARB_BLOCK_ACK(1), .ARB_LSB_HIGH_PRIORITY(1))
    u3 (.clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge), .grant(gr[3]), .grant_valid(gv[3]), .grant_encoded(ge[3]));
  priority_rr_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(0), .ARB_LSB_HIGH_PRIORITY(0))
    u4 (.clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge), .grant(gr[4]), .grant_valid(gv[4]), .grant_encoded(ge[4]));

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: holds per blocking rule, else searches requesters circularly
  // starting just after the last winner in priority order.
  task automatic model_step(input logic [3:0] r, input logic [3:0] a);
    for (int k = 0; k < NC; k++) begin
      bit hold;
      int start;
      int cand;
      int win;
      hold = 0;
      if (BLK_C[k] != 0 && m_idx[k] >= 0) begin
        if (ACK_C[k] == 0) hold = (r[m_idx[k]] == 1'b1);
        else               hold = (a[m_idx[k]] == 1'b0);
      end
      if (!hold) begin
        win = -1;
        if (RR_C[k] != 0 && m_last[k] >= 0)
          start = (LSB_C[k] != 0) ? (m_last[k] + 1) % 4 : (m_last[k] + 3) % 4;
        else
          start = (LSB_C[k] != 0) ? 0 : 3;
        for (int s = 0; s < 4; s++) begin
          cand = (LSB_C[k] != 0) ? (start + s) % 4 : (start - s + 4) % 4;
          if (win < 0 && r[cand]) win = cand;
        end
        m_idx[k] = win;
        if (win >= 0) m_last[k] = win;
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < NC; k++) begin
      int unsigned eg;
      eg = (m_idx[k] < 0) ? 0 : (1 << m_idx[k]);
      check($sformatf("c%0d grant", k), gr[k], eg);
      check($sformatf("c%0d valid", k), gv[k], (m_idx[k] >= 0) ? 1 : 0);
      check($sformatf("c%0d encoded", k), ge[k], (m_idx[k] < 0) ? 0 : m_idx[k]);
    end
  endtask

  // Called on a negedge; drives inputs, waits one rising edge, checks on the next negedge.
  task automatic cycle(input logic [3:0] r, input logic [3:0] a);
    request = r;
    acknowledge = a;
    model_step(r, a);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < NC; k++) begin
      m_idx[k] = -1;
      m_last[k] = -1;
    end
    compare_all();
    @(negedge clk);
    request = '0;
    acknowledge = '0;
    rst = 1'b1;
  endtask

  initial begin
    logic [3:0] r;
    logic [3:0] a;
    logic [3:0] rr_seq [5];
    for (int k = 0; k < NC; k++) begin
      m_idx[k] = -1;
      m_last[k] = -1;
    end
    @(negedge clk);
    @(negedge clk);
    compare_all();
    rst = 1'b1;

    // Round robin with acknowledge hold
    cycle(4'b0110, 4'b0000);
    check("rr_ack first grant", gr[0], 4'b0010);
    check("rr_ack first enc", ge[0], 1);
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0110, 4'b0000);
      check("rr_ack held", gr[0], 4'b0010);
    end
    cycle(4'b0110, 4'b0010);
    check("rr_ack second grant", gr[0], 4'b0100);
    check("rr_ack second enc", ge[0], 2);
    cycle(4'b0110, 4'b0100);
    check("rr_ack wrap grant", gr[0], 4'b0010);

    // Acknowledge with nothing pending
    do_reset();
    cycle(4'b0001, 4'b0000);
    check("ack_idle grant", gr[0], 4'b0001);
    cycle(4'b0000, 4'b0000);
    check("ack_idle held", gr[0], 4'b0001);
    cycle(4'b0000, 4'b0001);
    check("ack_idle released", gr[0], 4'b0000);
    check("ack_idle valid", gv[0], 0);

    // Fixed priority
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(4'b1010, 4'b1010);
      check("fixed msb grant", gr[1], 4'b1000);
      check("fixed msb enc", ge[1], 3);
      check("fixed lsb grant", gr[2], 4'b0010);
    end

    // Block without acknowledge
    do_reset();
    cycle(4'b0011, 4'b0000);
    check("blk first", gr[2], 4'b0001);
    cycle(4'b0011, 4'b0000);
    check("blk held", gr[2], 4'b0001);
    cycle(4'b0010, 4'b0000);
    check("blk release", gr[2], 4'b0010);

    // Non-blocking round robin rotation
    do_reset();
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1111, 4'b0000);
      check($sformatf("rr_rotate %0d", i), gr[3], rr_seq[i]);
    end

    // Reset mid-grant, then a single request
    do_reset();
    cycle(4'b0100, 4'b0000);
    check("post_reset grant", gr[0], 4'b0100);
    check("post_reset enc", ge[0], 2);

    // Random traffic with occasional resets
    r = '0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      if ($urandom_range(0, 2) == 0) r = 4'($urandom_range(0, 15));
      a = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      cycle(r, a);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
